// File: rtl/chain_blink_monitor_pkg.sv
// Shared types and helpers for the chainBlink LED bus monitor.
package chain_blink_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 17;
    localparam int POS_W     = $clog2(DEF_WIDTH);

    localparam int ROT_MAX   = 64;
    localparam int ROT_IDX_W = $clog2(ROT_MAX);

    // Rotate the low (msb+1) bits of v left by one; bit msb wraps into bit 0.
    function automatic logic [ROT_MAX-1:0] rotl1(input logic [ROT_MAX-1:0] v,
                                                 input logic [ROT_IDX_W-1:0] msb);
        logic [ROT_MAX-1:0] mask;
        mask = {ROT_MAX{1'b1}} >> (ROT_MAX - 1 - int'(msb));
        return ((v << 1) | ((v >> msb) & ROT_MAX'(1))) & mask;
    endfunction

endpackage

// File: rtl/chain_blink_monitor_if.sv
// LED bus plus monitor status outputs; master drives the bus, slave is the monitor.
interface chain_blink_monitor_if
    import chain_blink_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
);
    localparam int PW = $clog2(WIDTH);

    logic [WIDTH-1:0] led;
    logic             clr_cnt;
    logic [PW-1:0]    pos;
    logic             locked;
    logic             frozen;
    logic             step_pulse;
    logic             lap_pulse;
    logic             restart_pulse;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] lap_cnt;

    modport master (
        output led, clr_cnt,
        input  pos, locked, frozen, step_pulse, lap_pulse, restart_pulse,
               err_pulse, err_cnt, lap_cnt
    );

    modport slave (
        input  led, clr_cnt,
        output pos, locked, frozen, step_pulse, lap_pulse, restart_pulse,
               err_pulse, err_cnt, lap_cnt
    );

endinterface

// File: rtl/chain_blink_monitor_onehot_decode.sv
// Combinational one-hot check and bit-index decode of an LED vector.
module onehot_decode #(
    parameter int WIDTH = 17,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/chain_blink_monitor.sv
// Receive-side checker for the rotating one-hot chainBlink LED bus.
//   state | meaning
//   ACQ   | not locked; counting consecutive on-time advances
//   TRACK | locked; rotation advancing at the expected dwell
//   HOLD  | locked; pattern frozen on one position
module chain_blink_monitor
    import chain_blink_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int STEP_CYCLES = 1,
    parameter int LOCK_STEPS  = 2,
    parameter int CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst,
    chain_blink_monitor_if.slave mon
);

    localparam int PW = $clog2(WIDTH);
    localparam int DW = $clog2(STEP_CYCLES + 2);
    localparam int GW = $clog2(LOCK_STEPS + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [GW-1:0]    good_q, good_d;
    logic [PW-1:0]    pos_q;
    logic             step_q, step_d, lap_q, lap_d;
    logic             rstp_q, rstp_d, err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, lap_cnt_q;

    logic             valid;
    logic [PW-1:0]    idx;
    logic [ROT_MAX-1:0] rot_full;
    logic             adv, same, rst_ev, wrap;
    logic             on_time, early, reached;

    onehot_decode #(.WIDTH(WIDTH), .IDX_W(PW)) u_dec (
        .vec   (mon.led),
        .valid (valid),
        .idx   (idx)
    );

    always_comb begin
        rot_full = rotl1(ROT_MAX'(prev_q), ROT_IDX_W'(WIDTH - 1));
        adv      = valid && (mon.led == rot_full[WIDTH-1:0]);
        same     = valid && (mon.led == prev_q);
        rst_ev   = valid && (mon.led == WIDTH'(1)) && !adv && !same;
        wrap     = prev_q[WIDTH-1];
        on_time  = (int'(dwell_q) + 1) == STEP_CYCLES;
        early    = (int'(dwell_q) + 1) <  STEP_CYCLES;
        reached  = (int'(dwell_q) + 1) >= STEP_CYCLES;
    end

    always_comb begin
        if (adv || rst_ev)       dwell_d = '0;
        else if (dwell_q == '1)  dwell_d = dwell_q;
        else                     dwell_d = dwell_q + DW'(1);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        step_d  = 1'b0;
        lap_d   = 1'b0;
        rstp_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ACQ: begin
                good_d = '0;
                if (adv && on_time) begin
                    if (int'(good_q) + 1 >= LOCK_STEPS) state_d = TRACK;
                    else                                good_d  = good_q + GW'(1);
                end else if (rst_ev) begin
                    rstp_d = 1'b1;
                end
            end
            TRACK: begin
                if (adv) begin
                    if (early) begin
                        err_d = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        lap_d  = wrap;
                    end
                end else if (same) begin
                    if (reached) state_d = HOLD;
                end else if (rst_ev) begin
                    rstp_d  = 1'b1;
                    good_d  = '0;
                    state_d = ACQ;
                end else begin
                    err_d   = 1'b1;
                    good_d  = '0;
                    state_d = ACQ;
                end
            end
            HOLD: begin
                if (adv) begin
                    step_d  = 1'b1;
                    lap_d   = wrap;
                    state_d = TRACK;
                end else if (rst_ev) begin
                    rstp_d  = 1'b1;
                    good_d  = '0;
                    state_d = ACQ;
                end else if (!same) begin
                    err_d   = 1'b1;
                    good_d  = '0;
                    state_d = ACQ;
                end
            end
            default: begin
                good_d  = '0;
                state_d = ACQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ACQ;
            prev_q    <= '0;
            dwell_q   <= '0;
            good_q    <= '0;
            pos_q     <= '0;
            step_q    <= 1'b0;
            lap_q     <= 1'b0;
            rstp_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            lap_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            good_q  <= good_d;
            step_q  <= step_d;
            lap_q   <= lap_d;
            rstp_q  <= rstp_d;
            err_q   <= err_d;
            // Non-one-hot samples leave the reference and position untouched.
            if (valid) begin
                prev_q <= mon.led;
                pos_q  <= idx;
            end
            if (mon.clr_cnt)                     err_cnt_q <= '0;
            else if (err_d && err_cnt_q != '1)   err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (mon.clr_cnt)                     lap_cnt_q <= '0;
            else if (lap_d && lap_cnt_q != '1)   lap_cnt_q <= lap_cnt_q + CNT_W'(1);
        end
    end

    assign mon.pos           = pos_q;
    assign mon.locked        = (state_q == TRACK) || (state_q == HOLD);
    assign mon.frozen        = (state_q == HOLD);
    assign mon.step_pulse    = step_q;
    assign mon.lap_pulse     = lap_q;
    assign mon.restart_pulse = rstp_q;
    assign mon.err_pulse     = err_q;
    assign mon.err_cnt       = err_cnt_q;
    assign mon.lap_cnt       = lap_cnt_q;

endmodule

// File: tb/tb_chain_blink_monitor.sv
// Directed self-checking bench for chain_blink_monitor (WIDTH=17, STEP_CYCLES=1).
module tb_chain_blink_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    chain_blink_monitor_if #(.WIDTH(17), .CNT_W(8)) bus ();

    chain_blink_monitor #(
        .WIDTH(17), .STEP_CYCLES(1), .LOCK_STEPS(2), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .mon (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [16:0] v, input logic c);
        bus.led     = v;
        bus.clr_cnt = c;
        @(posedge clk);
        #1;
        bus.clr_cnt = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"},     32'(bus.pos), 0);
        chk({tag, "_locked"},  32'(bus.locked), 0);
        chk({tag, "_frozen"},  32'(bus.frozen), 0);
        chk({tag, "_pulses"},  32'({bus.step_pulse, bus.lap_pulse,
                                    bus.restart_pulse, bus.err_pulse}), 0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
        chk({tag, "_lap_cnt"}, 32'(bus.lap_cnt), 0);
    endtask

    initial begin
        bus.led     = '0;
        bus.clr_cnt = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Acquire from reset: 1 is a restart, 2 and 4 are the lock advances
        step(17'h00001, 0);
        chk("t1_restart", 32'(bus.restart_pulse), 1);
        chk("t1_lock0",   32'(bus.locked), 0);
        step(17'h00002, 0);
        chk("t1_lock1",   32'(bus.locked), 0);
        step(17'h00004, 0);
        chk("t1_lock2",   32'(bus.locked), 1);
        chk("t1_nostep",  32'(bus.step_pulse), 0);
        step(17'h00008, 0);
        chk("t1_step",    32'(bus.step_pulse), 1);
        chk("t1_pos",     32'(bus.pos), 3);
        chk("t1_err_cnt", 32'(bus.err_cnt), 0);

        // Freeze at 0x8 for 5 cycles, then advance
        step(17'h00008, 0);
        chk("t3_frozen_first", 32'(bus.frozen), 1);
        chk("t3_locked",       32'(bus.locked), 1);
        repeat (4) step(17'h00008, 0);
        chk("t3_frozen_last",  32'(bus.frozen), 1);
        chk("t3_nostep",       32'(bus.step_pulse), 0);
        step(17'h00010, 0);
        chk("t3_unfrozen",     32'(bus.frozen), 0);
        chk("t3_step",         32'(bus.step_pulse), 1);
        chk("t3_err_cnt",      32'(bus.err_cnt), 0);

        // Walk up to the MSB and wrap
        for (int b = 5; b <= 16; b++) begin
            step(17'd1 << b, 0);
            chk("t2_walk_step", 32'(bus.step_pulse), 1);
        end
        chk("t2_pos_msb", 32'(bus.pos), 16);
        step(17'h00001, 0);
        chk("t2_lap",      32'(bus.lap_pulse), 1);
        chk("t2_lap_cnt",  32'(bus.lap_cnt), 1);
        chk("t2_pos",      32'(bus.pos), 0);
        chk("t2_no_err",   32'(bus.err_pulse), 0);
        chk("t2_no_rst",   32'(bus.restart_pulse), 0);

        // Restart from 0x100 back to bit 0
        for (int b = 1; b <= 8; b++) step(17'd1 << b, 0);
        step(17'h00001, 0);
        chk("t4_restart",  32'(bus.restart_pulse), 1);
        chk("t4_unlock",   32'(bus.locked), 0);
        chk("t4_no_lap",   32'(bus.lap_pulse), 0);
        chk("t4_no_err",   32'(bus.err_pulse), 0);
        step(17'h00002, 0);
        step(17'h00004, 0);
        chk("t4_relock",   32'(bus.locked), 1);
        chk("t4_err_cnt",  32'(bus.err_cnt), 0);

        // Multi-hot while locked
        step(17'h00300, 0);
        chk("t5a_err",     32'(bus.err_pulse), 1);
        chk("t5a_err_cnt", 32'(bus.err_cnt), 1);
        chk("t5a_unlock",  32'(bus.locked), 0);
        chk("t5a_pos_hold", 32'(bus.pos), 2);
        step(17'h00008, 0);
        step(17'h00010, 0);
        step(17'h00020, 0);
        chk("t5a_relock",  32'(bus.locked), 1);

        // All-zero while locked
        step(17'h00000, 0);
        chk("t5b_err",     32'(bus.err_pulse), 1);
        chk("t5b_err_cnt", 32'(bus.err_cnt), 2);
        chk("t5b_unlock",  32'(bus.locked), 0);
        step(17'h00040, 0);
        step(17'h00080, 0);
        step(17'h00100, 0);
        chk("t5b_relock",  32'(bus.locked), 1);

        // Skipped position while locked
        step(17'h00200, 0);
        chk("t5c_step",    32'(bus.step_pulse), 1);
        step(17'h00800, 0);
        chk("t5c_err",     32'(bus.err_pulse), 1);
        chk("t5c_err_cnt", 32'(bus.err_cnt), 3);
        chk("t5c_unlock",  32'(bus.locked), 0);
        chk("t5c_pos",     32'(bus.pos), 11);

        // Drive err_cnt to saturation: restart, lock, drop to zero
        for (int k = 0; k < 252; k++) begin
            step(17'h00001, 0);
            step(17'h00002, 0);
            step(17'h00004, 0);
            step(17'h00000, 0);
        end
        chk("t6_err_cnt_255", 32'(bus.err_cnt), 255);
        step(17'h00001, 0);
        step(17'h00002, 0);
        step(17'h00004, 0);
        chk("t6_locked",      32'(bus.locked), 1);
        step(17'h00000, 0);
        chk("t6_sat_err",     32'(bus.err_pulse), 1);
        chk("t6_sat_cnt",     32'(bus.err_cnt), 255);

        // Clear coincident with an error
        step(17'h00001, 0);
        step(17'h00002, 0);
        step(17'h00004, 0);
        step(17'h00000, 1);
        chk("t6_clr_err_pulse", 32'(bus.err_pulse), 1);
        chk("t6_clr_err_cnt",   32'(bus.err_cnt), 0);
        chk("t6_clr_lap_cnt",   32'(bus.lap_cnt), 0);
        step(17'h00001, 0);
        step(17'h00002, 0);
        step(17'h00004, 0);
        step(17'h00000, 0);
        chk("t6_post_clr_cnt",  32'(bus.err_cnt), 1);

        // Async reset while frozen
        step(17'h00001, 0);
        step(17'h00002, 0);
        step(17'h00004, 0);
        step(17'h00004, 0);
        chk("t6_hold",     32'(bus.frozen), 1);
        chk("t6_hold_pos", 32'(bus.pos), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chain_blink_monitor.md
Name: chain_blink_monitor

Overview:
- Observer/checker at the receiving end of the chainBlink LED bus: samples the one-hot rotating LED vector every clock and decodes the lit position.
- Verifies legal rotation, dwell timing, freeze holds and restarts; reports lock state, events and error/lap counters.
- Used in-system on the LED bus and as a self-checking monitor in benches.

Parameters:
WIDTH, 17, LED bus width (number of chain positions)
STEP_CYCLES, 1, expected dwell cycles per position; dwell longer than this means freeze
LOCK_STEPS, 2, consecutive legal advances required to reach TRACK
CNT_W, 8, width of err_cnt and lap_cnt (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
led  in  WIDTH  observed LED vector, synchronous to clk
clr_cnt  in  1  synchronous clear of err_cnt and lap_cnt
pos  out  $clog2(WIDTH)  index of the lit LED (last valid)
locked  out  1  high in TRACK or HOLD
frozen  out  1  high in HOLD
step_pulse  out  1  one-cycle pulse per legal advance
lap_pulse  out  1  one-cycle pulse on wrap MSB->bit0
restart_pulse  out  1  one-cycle pulse on non-adjacent jump to bit0
err_pulse  out  1  one-cycle pulse on protocol violation while locked
err_cnt  out  CNT_W  saturating error count
lap_cnt  out  CNT_W  saturating lap count

Behaviour:
- Reset (rst=0, async): all outputs 0; state ACQ; prev=0; dwell=0; good=0.
- Each clk: classify led vs prev. ADV = led == rotate-left-by-1(prev), with bit WIDTH-1 -> bit0. SAME = led == prev. RST = led == 1 and not ADV and not SAME. BAD = not one-hot (zero or multi-hot), or any other change.
- All outputs registered: an event at led on cycle N appears on outputs at edge N+1 (latency 1).
- dwell counts cycles since the last change; it is saturating and is cleared on ADV or RST.
- pos updates on every valid one-hot sample. Sample is held on BAD.

States:
- ACQ:
  - ADV with dwell+1 == STEP_CYCLES -> good++. Reaching LOCK_STEPS -> TRACK.
  - RST -> good=0 and restart_pulse.
  - BAD or SAME -> good=0.
  - No err_pulse is raised in ACQ.
- TRACK:
  - ADV with correct dwell -> step_pulse. From WIDTH-1 -> 0 also lap_pulse and lap_cnt++.
  - SAME with dwell reaching STEP_CYCLES -> HOLD.
  - ADV early (dwell+1 < STEP_CYCLES) -> err.
  - RST -> restart_pulse, good=0, ACQ, no error.
  - BAD -> err, ACQ.
- HOLD:
  - SAME -> stay.
  - ADV (any dwell) -> step_pulse (+lap on wrap), TRACK.
  - RST -> restart_pulse, ACQ.
  - BAD -> err, ACQ.
- err means err_pulse=1 and err_cnt++ (saturating at 2^CNT_W-1).
- clr_cnt:
  - Zeroes both counters.
  - Clear wins over a simultaneous increment; the pulses still fire.
- Counters saturate; they never wrap.
- Reset mid-HOLD/TRACK: immediate return to reset values.
- With STEP_CYCLES=1, any SAME in TRACK enters HOLD on that cycle.

Decomposition:
- Package chain_blink_pkg:
  - state enum {ACQ, TRACK, HOLD}
  - default WIDTH
  - POS_W = $clog2(WIDTH)
  - rotate-left function
- Sub-module onehot_decode:
  - Combinational.
  - Inputs: WIDTH vector.
  - Outputs: valid (exactly one bit set) and index.
  - Reused by the chainBlink bench.

Test Plan:
1. Reset, then led=1,2,4,8 one per cycle (STEP_CYCLES=1) -> locked=1 after the 2nd advance; step_pulse on each later advance; pos=3; err_cnt=0.
2. Locked at 0x10000, next led=0x00001 -> lap_pulse=1, lap_cnt=1, pos=0, no err_pulse.
3. Locked at 0x00008, hold led 5 cycles then 0x00010 -> frozen=1 from the cycle after the first repeat; frozen=0 with step_pulse on the advance; err_cnt=0.
4. Locked at 0x00100, led=0x00001 -> restart_pulse=1, locked=0; relock after 2 advances; err_cnt=0.
5. Locked, led=0x00300 or 0x00000 or skip 0x00008->0x00020 -> err_pulse=1, err_cnt+1, locked=0.
6. Force err_cnt=255 via repeated errors -> stays 255. Assert clr_cnt together with an error -> err_cnt=0, err_pulse=1. Assert rst during HOLD -> all outputs 0 without waiting for a clk edge.
